// File: rtl/multicycle_control_if.sv
// Instruction fields and status in from the datapath, control strobes and selects out to it.
// master: the control unit. slave: the datapath it steers.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pcWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic       regWrite;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] immSrc;
  logic [2:0] aluControl;

  // Plain level signals, no valid/ready: every output is meaningful on every cycle.
  modport master (
    input  op, funct3, funct7b5, zero,
    output pcWrite, adrSrc, memWrite, irWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, immSrc, aluControl
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pcWrite, adrSrc, memWrite, irWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, immSrc, aluControl
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM plus ALU and immediate decoders for the multicycle RV32I datapath.
// Moore control word is registered together with the state; write enables are gated by reset.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus,
  output logic [STATE_W-1:0]  state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  typedef struct packed {
    logic       pcUpdate;
    logic       branch;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
  } ctrl_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RALU = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t curState;
  state_t nextState;
  ctrl_t  ctrlQ;

  function automatic ctrl_t controlFor(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irWrite   = 1'b1;
        c.pcUpdate  = 1'b1;
        c.aluSrcB   = 2'b10;
        c.resultSrc = 2'b10;
      end
      DECODE: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b01;
      end
      MEMADR: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
      end
      MEMREAD: begin
        c.adrSrc = 1'b1;
      end
      MEMWB: begin
        c.resultSrc = 2'b01;
        c.regWrite  = 1'b1;
      end
      MEMWRITE: begin
        c.adrSrc   = 1'b1;
        c.memWrite = 1'b1;
      end
      EXECUTER: begin
        c.aluSrcA = 2'b10;
        c.aluOp   = 2'b10;
      end
      EXECUTEI: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
        c.aluOp   = 2'b10;
      end
      ALUWB: begin
        c.regWrite = 1'b1;
      end
      JAL: begin
        c.aluSrcA  = 2'b01;
        c.aluSrcB  = 2'b10;
        c.pcUpdate = 1'b1;
      end
      BEQ: begin
        c.aluSrcA = 2'b10;
        c.aluOp   = 2'b01;
        c.branch  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Unknown opcodes fall back to FETCH from DECODE, so an illegal instruction costs two cycles.
  always_comb begin
    nextState = FETCH;
    case (curState)
      FETCH:  nextState = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_RALU:      nextState = EXECUTER;
          OP_IALU:      nextState = EXECUTEI;
          OP_JAL:       nextState = JAL;
          OP_BEQ:       nextState = BEQ;
          default:      nextState = FETCH;
        endcase
      end
      MEMADR:   nextState = bus.op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  nextState = MEMWB;
      MEMWB:    nextState = FETCH;
      MEMWRITE: nextState = FETCH;
      EXECUTER: nextState = ALUWB;
      EXECUTEI: nextState = ALUWB;
      JAL:      nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      BEQ:      nextState = FETCH;
      default:  nextState = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curState <= FETCH;
      ctrlQ    <= controlFor(FETCH);
    end else begin
      curState <= nextState;
      ctrlQ    <= controlFor(nextState);
    end
  end

  // zero arrives from the ALU in the BEQ cycle itself, so the branch term stays combinational.
  assign bus.pcWrite  = ~reset & (ctrlQ.pcUpdate | (ctrlQ.branch & bus.zero));
  assign bus.irWrite  = ~reset & ctrlQ.irWrite;
  assign bus.regWrite = ~reset & ctrlQ.regWrite;
  assign bus.memWrite = ~reset & ctrlQ.memWrite;

  assign bus.adrSrc    = ctrlQ.adrSrc;
  assign bus.resultSrc = ctrlQ.resultSrc;
  assign bus.aluSrcA   = ctrlQ.aluSrcA;
  assign bus.aluSrcB   = ctrlQ.aluSrcB;

  always_comb begin
    bus.immSrc = 2'b00;
    case (bus.op)
      OP_SW:   bus.immSrc = 2'b01;
      OP_BEQ:  bus.immSrc = 2'b10;
      OP_JAL:  bus.immSrc = 2'b11;
      default: bus.immSrc = 2'b00;
    endcase
  end

  // Subtract only for R-type with funct7b5 set; I-type funct3=000 is always addi.
  always_comb begin
    bus.aluControl = 3'b000;
    case (ctrlQ.aluOp)
      2'b01: bus.aluControl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.aluControl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.aluControl = 3'b101;
          3'b110:  bus.aluControl = 3'b011;
          3'b111:  bus.aluControl = 3'b010;
          default: bus.aluControl = 3'b000;
        endcase
      end
      default: bus.aluControl = 3'b000;
    endcase
  end

  assign state = STATE_W'(curState);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instructions checked per cycle
// against an instruction-level model of paths, write strobes and decoder outputs.
module tb_multicycle_control;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RALU = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef int intQ_t[$];

  logic       clk;
  logic       reset;
  logic [3:0] dutState;
  int         vecCount;
  int         errCount;

  multicycle_control_if bus ();

  multicycle_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master),
    .state (dutState)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecCount++;
    if (got !== want) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic intQ_t pathOf(input logic [6:0] op);
    intQ_t p;
    case (op)
      OP_LW:   p = '{0, 1, 2, 3, 4};
      OP_SW:   p = '{0, 1, 2, 5};
      OP_RALU: p = '{0, 1, 6, 7};
      OP_IALU: p = '{0, 1, 8, 7};
      OP_JAL:  p = '{0, 1, 9, 7};
      OP_BEQ:  p = '{0, 1, 10};
      default: p = '{0, 1};
    endcase
    return p;
  endfunction

  function automatic logic [1:0] immOf(input logic [6:0] op);
    if (op == OP_SW)  return 2'b01;
    if (op == OP_BEQ) return 2'b10;
    if (op == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] aluDecode(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == OP_RALU && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit isLegal(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_RALU || op == OP_IALU ||
           op == OP_JAL || op == OP_BEQ;
  endfunction

  // ---------------- driver ----------------
  // abortAt >= 0 raises reset just before that cycle of the instruction and stops there.
  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input int abortAt);
    intQ_t path;
    bit    writesReg;
    bit    isLast;
    bit    aborted;
    string nm;
    path = pathOf(op);
    writesReg = (op == OP_LW || op == OP_RALU || op == OP_IALU || op == OP_JAL);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.zero     = z;
    for (int k = 0; k < path.size(); k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        if (k == abortAt) reset = 1'b1;
      end
      @(negedge clk);
      aborted = (k == abortAt);
      isLast  = (k == path.size() - 1);
      nm = $sformatf("op%b.c%0d", op, k);
      checkVal({nm, ".state"}, 32'(dutState), 32'(path[k]));
      if (aborted) begin
        checkVal({nm, ".rstPcWrite"},  32'(bus.pcWrite), 32'd0);
        checkVal({nm, ".rstIrWrite"},  32'(bus.irWrite), 32'd0);
        checkVal({nm, ".rstRegWrite"}, 32'(bus.regWrite), 32'd0);
        checkVal({nm, ".rstMemWrite"}, 32'(bus.memWrite), 32'd0);
        break;
      end
      checkVal({nm, ".irWrite"}, 32'(bus.irWrite), 32'(k == 0));
      checkVal({nm, ".pcWrite"}, 32'(bus.pcWrite),
               32'(k == 0 || (op == OP_JAL && k == 2) || (op == OP_BEQ && k == 2 && z)));
      checkVal({nm, ".regWrite"}, 32'(bus.regWrite), 32'(isLast && writesReg));
      checkVal({nm, ".memWrite"}, 32'(bus.memWrite), 32'(isLast && op == OP_SW));
      checkVal({nm, ".adrSrc"}, 32'(bus.adrSrc),
               32'((op == OP_LW || op == OP_SW) && k == 3));
      checkVal({nm, ".immSrc"}, 32'(bus.immSrc), 32'(immOf(op)));
      if (op == OP_BEQ && k == 2)
        checkVal({nm, ".aluControl"}, 32'(bus.aluControl), 32'd1);
      else if ((op == OP_RALU || op == OP_IALU) && k == 2)
        checkVal({nm, ".aluControl"}, 32'(bus.aluControl), 32'(aluDecode(op, f3, f7)));
      else
        checkVal({nm, ".aluControl"}, 32'(bus.aluControl), 32'd0);
      if (k == 0) begin
        checkVal({nm, ".resultSrc"}, 32'(bus.resultSrc), 32'd2);
        checkVal({nm, ".aluSrcA"},   32'(bus.aluSrcA),   32'd0);
        checkVal({nm, ".aluSrcB"},   32'(bus.aluSrcB),   32'd2);
      end
      if (k == 1) begin
        checkVal({nm, ".aluSrcA"}, 32'(bus.aluSrcA), 32'd1);
        checkVal({nm, ".aluSrcB"}, 32'(bus.aluSrcB), 32'd1);
      end
      if (k == 2 && path.size() > 2) begin
        checkVal({nm, ".aluSrcA"}, 32'(bus.aluSrcA), (op == OP_JAL) ? 32'd1 : 32'd2);
        checkVal({nm, ".aluSrcB"}, 32'(bus.aluSrcB),
                 (op == OP_JAL) ? 32'd2 : (op == OP_RALU || op == OP_BEQ) ? 32'd0 : 32'd1);
      end
      if (isLast && writesReg)
        checkVal({nm, ".wbResultSrc"}, 32'(bus.resultSrc), (op == OP_LW) ? 32'd1 : 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] rop;
    int         pick;
    vecCount     = 0;
    errCount     = 0;
    reset        = 1'b1;
    bus.op       = 7'd0;
    bus.funct3   = 3'd0;
    bus.funct7b5 = 1'b0;
    bus.zero     = 1'b0;

    @(negedge clk);
    checkVal("rst0.pcWrite",  32'(bus.pcWrite),  32'd0);
    checkVal("rst0.irWrite",  32'(bus.irWrite),  32'd0);
    checkVal("rst0.regWrite", 32'(bus.regWrite), 32'd0);
    checkVal("rst0.memWrite", 32'(bus.memWrite), 32'd0);
    @(negedge clk);
    checkVal("rst1.state",    32'(dutState),     32'd0);
    checkVal("rst1.pcWrite",  32'(bus.pcWrite),  32'd0);
    checkVal("rst1.irWrite",  32'(bus.irWrite),  32'd0);
    checkVal("rst1.regWrite", 32'(bus.regWrite), 32'd0);
    checkVal("rst1.memWrite", 32'(bus.memWrite), 32'd0);

    runInstr(OP_RALU, 3'b000, 1'b1, 1'b0, -1);
    runInstr(OP_RALU, 3'b000, 1'b0, 1'b1, -1);
    runInstr(OP_LW,   3'b010, 1'b0, 1'b0, -1);
    runInstr(OP_SW,   3'b010, 1'b0, 1'b0, -1);
    runInstr(OP_BEQ,  3'b000, 1'b0, 1'b1, -1);
    runInstr(OP_BEQ,  3'b000, 1'b0, 1'b0, -1);
    runInstr(OP_IALU, 3'b110, 1'b0, 1'b0, -1);
    runInstr(OP_IALU, 3'b000, 1'b1, 1'b0, -1);
    runInstr(OP_JAL,  3'b000, 1'b0, 1'b1, -1);
    runInstr(7'b0000000, 3'b000, 1'b0, 1'b1, -1);
    runInstr(OP_LW,   3'b010, 1'b0, 1'b0, 3);
    runInstr(OP_RALU, 3'b111, 1'b0, 1'b0, -1);
    runInstr(OP_LW,   3'b010, 1'b0, 1'b0, 4);
    runInstr(OP_SW,   3'b010, 1'b0, 1'b0, 3);
    runInstr(OP_IALU, 3'b010, 1'b0, 1'b0, -1);

    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 6);
      case (pick)
        0: rop = OP_LW;
        1: rop = OP_SW;
        2: rop = OP_RALU;
        3: rop = OP_IALU;
        4: rop = OP_JAL;
        5: rop = OP_BEQ;
        default: begin
          rop = 7'($urandom_range(0, 127));
          while (isLegal(rop)) rop = 7'($urandom_range(0, 127));
        end
      endcase
      runInstr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
